// File: rtl/sc_life_manager.sv
// rtl/sc_life_manager.sv - Frogger lives counter with hit hold-off, bonus saturation and game-over.
module sc_life_manager #(
    parameter int DATAWIDTH      = 4,
    parameter int INIT_LIVES     = 3,
    parameter int MAX_LIVES      = 9,
    parameter int HOLDOFF_CYCLES = 50000000,
    parameter int HOLDOFF_WIDTH  = 26
) (
    input  logic                 sc_life_manager_CLOCK_50,
    input  logic                 sc_life_manager_RESET_InLow,
    input  logic                 sc_life_manager_start_InLow,
    input  logic                 sc_life_manager_hit_InLow,
    input  logic                 sc_life_manager_bonus_InLow,
    output logic [DATAWIDTH-1:0] sc_life_manager_lives_OutBUS,
    output logic                 sc_life_manager_gameover_OutHigh,
    output logic                 sc_life_manager_invulnerable_OutHigh,
    output logic                 sc_life_manager_lifelost_OutHigh,
    output logic                 sc_life_manager_lifegained_OutHigh
);

    localparam logic [DATAWIDTH-1:0]     INIT_L = DATAWIDTH'(INIT_LIVES);
    localparam logic [DATAWIDTH-1:0]     MAX_L  = DATAWIDTH'(MAX_LIVES);
    localparam logic [DATAWIDTH-1:0]     ONE_L  = DATAWIDTH'(1);
    localparam logic [HOLDOFF_WIDTH-1:0] HOLD_L = HOLDOFF_WIDTH'(HOLDOFF_CYCLES - 1);
    localparam logic [HOLDOFF_WIDTH-1:0] ONE_C  = HOLDOFF_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAYING,
        ST_HOLDOFF,
        ST_GAMEOVER
    } state_t;

    state_t                  r_state;
    logic [DATAWIDTH-1:0]    r_lives;
    logic [HOLDOFF_WIDTH-1:0] r_cnt;
    logic                    r_armed;
    logic                    r_start_prev;
    logic                    r_hit_prev;
    logic                    r_bonus_prev;
    logic                    r_gameover;
    logic                    r_invuln;
    logic                    r_lost;
    logic                    r_gained;

    logic                    w_start_ev;
    logic                    w_hit_ev;
    logic                    w_bonus_ev;
    logic [DATAWIDTH-1:0]    w_dec;
    logic                    w_can_inc;
    logic                    w_dec_can_inc;

    // r_armed masks the first edge after reset so a level held low across release is not an event
    assign w_start_ev    = r_armed & r_start_prev & ~sc_life_manager_start_InLow;
    assign w_hit_ev      = r_armed & r_hit_prev   & ~sc_life_manager_hit_InLow;
    assign w_bonus_ev    = r_armed & r_bonus_prev & ~sc_life_manager_bonus_InLow;
    assign w_dec         = r_lives - ONE_L;
    assign w_can_inc     = (r_lives < MAX_L);
    assign w_dec_can_inc = (w_dec < MAX_L);

    always_ff @(posedge sc_life_manager_CLOCK_50 or negedge sc_life_manager_RESET_InLow) begin
        if (!sc_life_manager_RESET_InLow) begin
            r_state      <= ST_IDLE;
            r_lives      <= '0;
            r_cnt        <= '0;
            r_armed      <= 1'b0;
            r_start_prev <= 1'b1;
            r_hit_prev   <= 1'b1;
            r_bonus_prev <= 1'b1;
            r_gameover   <= 1'b0;
            r_invuln     <= 1'b0;
            r_lost       <= 1'b0;
            r_gained     <= 1'b0;
        end else begin
            r_armed      <= 1'b1;
            r_start_prev <= sc_life_manager_start_InLow;
            r_hit_prev   <= sc_life_manager_hit_InLow;
            r_bonus_prev <= sc_life_manager_bonus_InLow;
            r_lost       <= 1'b0;
            r_gained     <= 1'b0;
            if (w_start_ev) begin
                r_state    <= ST_PLAYING;
                r_lives    <= INIT_L;
                r_cnt      <= '0;
                r_gameover <= 1'b0;
                r_invuln   <= 1'b0;
            end else begin
                case (r_state)
                    ST_PLAYING: begin
                        if (w_hit_ev) begin
                            r_lost <= 1'b1;
                            if (w_bonus_ev) begin
                                // decrement then saturating increment: never reaches zero here
                                r_lives  <= w_dec_can_inc ? (w_dec + ONE_L) : MAX_L;
                                r_gained <= w_dec_can_inc;
                                r_state  <= ST_HOLDOFF;
                                r_cnt    <= HOLD_L;
                                r_invuln <= 1'b1;
                            end else begin
                                r_lives <= w_dec;
                                if (w_dec == '0) begin
                                    r_state    <= ST_GAMEOVER;
                                    r_gameover <= 1'b1;
                                end else begin
                                    r_state  <= ST_HOLDOFF;
                                    r_cnt    <= HOLD_L;
                                    r_invuln <= 1'b1;
                                end
                            end
                        end else if (w_bonus_ev && w_can_inc) begin
                            r_lives  <= r_lives + ONE_L;
                            r_gained <= 1'b1;
                        end
                    end
                    ST_HOLDOFF: begin
                        if (w_bonus_ev && w_can_inc) begin
                            r_lives  <= r_lives + ONE_L;
                            r_gained <= 1'b1;
                        end
                        if (r_cnt == '0) begin
                            r_state  <= ST_PLAYING;
                            r_invuln <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - ONE_C;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign sc_life_manager_lives_OutBUS         = r_lives;
    assign sc_life_manager_gameover_OutHigh     = r_gameover;
    assign sc_life_manager_invulnerable_OutHigh = r_invuln;
    assign sc_life_manager_lifelost_OutHigh     = r_lost;
    assign sc_life_manager_lifegained_OutHigh   = r_gained;

endmodule

// File: tb/tb_sc_life_manager.sv
// tb/tb_sc_life_manager.sv - scoreboard bench for sc_life_manager against a behavioural lives model.
module tb_sc_life_manager;

    localparam int DW    = 4;
    localparam int INIT  = 3;
    localparam int MAXL  = 5;
    localparam int HOLD  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_n = 1'b1;
    logic          h_n = 1'b1;
    logic          b_n = 1'b1;
    logic [DW-1:0] lives;
    logic          go, inv, lost, gained;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int lives;
        bit go;
        bit inv;
        bit lost;
        bit gained;
    } exp_t;

    exp_t exp_q[$];

    sc_life_manager #(
        .DATAWIDTH(DW), .INIT_LIVES(INIT), .MAX_LIVES(MAXL),
        .HOLDOFF_CYCLES(HOLD), .HOLDOFF_WIDTH(26)
    ) dut (
        .sc_life_manager_CLOCK_50(clk),
        .sc_life_manager_RESET_InLow(rst_n),
        .sc_life_manager_start_InLow(s_n),
        .sc_life_manager_hit_InLow(h_n),
        .sc_life_manager_bonus_InLow(b_n),
        .sc_life_manager_lives_OutBUS(lives),
        .sc_life_manager_gameover_OutHigh(go),
        .sc_life_manager_invulnerable_OutHigh(inv),
        .sc_life_manager_lifelost_OutHigh(lost),
        .sc_life_manager_lifegained_OutHigh(gained)
    );

    always #10 clk = ~clk;

    // Game model: alive = a game is in progress; inv_left = invulnerable clocks still to show
    int m_lives, m_inv_left;
    bit m_alive, m_over, m_armed;
    bit m_ps, m_ph, m_pb;

    task automatic model_reset();
        m_lives = 0; m_inv_left = 0; m_alive = 0; m_over = 0; m_armed = 0;
        m_ps = 1; m_ph = 1; m_pb = 1;
    endtask

    task automatic model_step(input bit s, input bit h, input bit b);
        bit se, he, be, shielded, lost_e, gain_e;
        exp_t e;
        se = m_armed && m_ps && !s;
        he = m_armed && m_ph && !h;
        be = m_armed && m_pb && !b;
        m_armed = 1; m_ps = s; m_ph = h; m_pb = b;
        lost_e = 0; gain_e = 0;
        if (se) begin
            m_lives = INIT; m_alive = 1; m_over = 0; m_inv_left = 0;
        end else if (m_alive) begin
            shielded = (m_inv_left > 0);
            if (shielded) m_inv_left--;
            if (!shielded && he) begin
                m_lives--; lost_e = 1;
                if (m_lives == 0 && !be) begin
                    m_alive = 0; m_over = 1;
                end else begin
                    m_inv_left = HOLD;
                end
            end
            if (be && m_alive && m_lives < MAXL) begin
                m_lives++; gain_e = 1;
            end
        end
        e.lives = m_lives; e.go = m_over; e.inv = m_alive && (m_inv_left > 0);
        e.lost = lost_e; e.gained = gain_e;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit s, input bit h, input bit b);
        s_n = s; h_n = h; b_n = b;
        @(posedge clk);
        model_step(s, h, b);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 1, 1);
    endtask

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("lives",      int'(lives),  e.lives);
            chk("gameover",   int'(go),     int'(e.go));
            chk("invuln",     int'(inv),    int'(e.inv));
            chk("lifelost",   int'(lost),   int'(e.lost));
            chk("lifegained", int'(gained), int'(e.gained));
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_lives"}, int'(lives), 0);
        chk({tag, "_go"},    int'(go),    0);
        chk({tag, "_inv"},   int'(inv),   0);
        chk({tag, "_lost"},  int'(lost),  0);
        chk({tag, "_gain"},  int'(gained), 0);
    endtask

    initial begin
        model_reset();
        #5;
        check_reset_vals("por");
        #30 rst_n = 1'b1;
        idle(1);
        // hits in IDLE are ignored
        cyc(1, 0, 1); idle(1); cyc(1, 0, 1); idle(1);
        cyc(0, 1, 1); idle(2);
        // hit, hit during hold-off, hit after hold-off
        cyc(1, 0, 1); idle(1); cyc(1, 0, 1); idle(4);
        cyc(1, 0, 1); idle(5);
        // back to game over, then abuse inputs there
        cyc(1, 0, 1); idle(5);
        cyc(1, 0, 1); cyc(1, 1, 0); cyc(1, 0, 0); idle(2);
        cyc(0, 1, 1); idle(1);
        // four bonuses from 3, then a long held bonus
        for (int i = 0; i < 4; i++) begin cyc(1, 1, 0); idle(1); end
        for (int i = 0; i < 10; i++) cyc(1, 1, 0);
        idle(1);
        // drop to one life, then hit+bonus together
        cyc(0, 1, 1); idle(1);
        cyc(1, 0, 1); idle(5); cyc(1, 0, 1); idle(5);
        cyc(1, 0, 0); idle(6);
        cyc(1, 1, 1); cyc(0, 0, 0); idle(2);
        // async reset in the middle of hold-off, start held low across release
        cyc(1, 0, 1); idle(1);
        @(negedge clk); #2;
        rst_n = 1'b0; s_n = 1'b0;
        #1;
        check_reset_vals("async");
        model_reset();
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc(0, 1, 1);
        cyc(1, 1, 1); cyc(0, 1, 1); idle(2);
        // randomized play
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 59) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
        end
        @(negedge clk); #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
